// File: rtl/dmem_access_arbiter_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package dmem_access_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_ACCESS = 2'd1;
    localparam arb_state_t ST_DONE   = 2'd2;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    localparam int DEF_WAIT_CYCLES = 1;
    localparam int DEF_DEPTH       = 64;

    // Misaligned or beyond the last word: rejected without touching memory.
    function automatic logic addr_bad(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection between pipeline and loader ports.
// DMEM_ARB_RR_EN selects round-robin tie-breaking; default is fixed priority to the pipeline.
module dmem_arb_pick
    import dmem_access_arbiter_pkg::*;
(
    input  logic p_req,
    input  logic l_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = p_req | l_req;

`ifdef DMEM_ARB_RR_EN
    assign grant_id = (p_req && l_req) ? ~last_grant : (p_req ? PORT_PIPE : PORT_LOAD);
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant_id = p_req ? PORT_PIPE : PORT_LOAD;
`endif

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage and the loader port.
// Tie-breaking policy is chosen in dmem_arb_pick via DMEM_ARB_RR_EN.
module dmem_access_arbiter
    import dmem_access_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [31:0]   p_addr,
    input  logic [31:0]   p_wdata,
    output logic          p_ack,
    output logic [31:0]   p_rdata,
    output logic          p_err,
    output logic          p_stall,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_ack,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    output logic          mem_r_en,
    output logic          mem_w_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_st_val,
    input  logic [31:0]   mem_rd_val
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitrates and latches the winner
    // ACCESS | memory cycle with cnt wait states remaining
    // DONE   | issues the owner's one-cycle ack on the next edge

    arb_state_t    state;
    logic [3:0]    cnt;
    logic          owner;
    logic          we_q;
    logic          err_q;
    logic          last_grant;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          grant_valid;
    logic          grant_id;
    logic [31:0]   sel_addr;
    logic          sel_bad;
    logic          in_access;

    dmem_arb_pick u_pick (
        .p_req       (p_req),
        .l_req       (l_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_addr = (grant_id == PORT_LOAD) ? l_addr : p_addr;
    assign sel_bad  = addr_bad(sel_addr, DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= PORT_PIPE;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            last_grant <= PORT_LOAD;
            addr_q     <= '0;
            wdata_q    <= '0;
            p_ack      <= 1'b0;
            l_ack      <= 1'b0;
            p_err      <= 1'b0;
            l_err      <= 1'b0;
            p_rdata    <= '0;
            l_rdata    <= '0;
        end else begin
            p_ack <= 1'b0;
            l_ack <= 1'b0;
            p_err <= 1'b0;
            l_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        we_q       <= (grant_id == PORT_LOAD) ? l_we : p_we;
                        wdata_q    <= (grant_id == PORT_LOAD) ? l_wdata : p_wdata;
                        addr_q     <= sel_addr[AW+1:2];
                        err_q      <= sel_bad;
                        cnt        <= 4'(WAIT_CYCLES);
                        state      <= sel_bad ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_q) begin
                            if (owner == PORT_LOAD) l_rdata <= mem_rd_val;
                            else                    p_rdata <= mem_rd_val;
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (owner == PORT_LOAD) begin
                        l_ack <= 1'b1;
                        l_err <= err_q;
                    end else begin
                        p_ack <= 1'b1;
                        p_err <= err_q;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only the last wait-state cycle writes, so one access commits exactly once.
    assign in_access  = (state == ST_ACCESS);
    assign mem_r_en   = in_access & ~we_q;
    assign mem_w_en   = in_access & we_q & (cnt == 4'd0);
    assign mem_addr   = in_access ? addr_q : '0;
    assign mem_st_val = in_access ? wdata_q : '0;

    assign p_stall = p_req & ~p_ack;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter against a transaction-level model.
module tb_dmem_access_arbiter;

    localparam int W     = 1;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          p_req, p_we, p_ack, p_err, p_stall;
    logic [31:0]   p_addr, p_wdata, p_rdata;
    logic          l_req, l_we, l_ack, l_err;
    logic [31:0]   l_addr, l_wdata, l_rdata;
    logic          mem_r_en, mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_st_val, mem_rd_val;

    logic [31:0]   tb_mem [DEPTH];
    logic          seed_mem = 1'b1;
    int            w_total = 0;
    int            r_total = 0;
    logic [AW-1:0] last_w_addr;
    logic [31:0]   last_w_data;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   ref_mem [DEPTH];
    logic [31:0]   exp_rdata [2];
    int            last_m;
    txn_t          pq [$];
    txn_t          lq [$];

    dmem_access_arbiter #(.WAIT_CYCLES(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_rdata(p_rdata), .p_err(p_err), .p_stall(p_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata), .l_err(l_err),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_st_val(mem_st_val), .mem_rd_val(mem_rd_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_val(input int i);
        return 32'h1357_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Behavioural memory the DUT talks to.
    assign mem_rd_val = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= seed_val(i);
        end else if (mem_w_en) begin
            tb_mem[mem_addr] <= mem_st_val;
            w_total          <= w_total + 1;
            last_w_addr      <= mem_addr;
            last_w_data      <= mem_st_val;
        end
    end
    always @(posedge clk) if (mem_r_en) r_total <= r_total + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic txn_bad(input txn_t t);
        return (t.addr % 4 != 0) || (t.addr / 4 >= DEPTH);
    endfunction

    function automatic int pick_m(input bit a0, input bit a1, input int last);
        if (a0 && a1) begin
`ifdef DMEM_ARB_RR_EN
            return 1 - last;
`else
            return 0;
`endif
        end
        return a0 ? 0 : 1;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        r       = $urandom_range(0, 9);
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        if (r == 0)      t.addr = 32'(DEPTH * 4) + ($urandom_range(0, 255) << 2);
        else if (r == 1) t.addr = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
        else             t.addr = $urandom_range(0, 15) << 2;
        return t;
    endfunction

    function automatic logic get_err(input int i);
        return (i == 1) ? l_err : p_err;
    endfunction

    function automatic logic [31:0] get_rdata(input int i);
        return (i == 1) ? l_rdata : p_rdata;
    endfunction

    task automatic drive_port(input int i, input logic req, input txn_t t);
        if (i == 1) begin
            l_req = req; l_we = t.we; l_addr = t.addr; l_wdata = t.wdata;
        end else begin
            p_req = req; p_we = t.we; p_addr = t.addr; p_wdata = t.wdata;
        end
    endtask

    task automatic complete(input int i, input txn_t t, input int wsnap, input int rsnap);
        logic bad;
        int   wd;
        bad = txn_bad(t);
        wd  = int'(t.addr / 4);
        chk($sformatf("port%0d_err", i), 32'(get_err(i)), 32'(bad));
        if (!bad && t.we)  ref_mem[wd] = t.wdata;
        if (!bad && !t.we) exp_rdata[i] = ref_mem[wd];
        chk($sformatf("port%0d_rdata", i), get_rdata(i), exp_rdata[i]);
        chk($sformatf("port%0d_rdata_other", 1 - i), get_rdata(1 - i), exp_rdata[1 - i]);
        chk("write_commits", 32'(w_total - wsnap), (!bad && t.we) ? 32'd1 : 32'd0);
        chk("read_en_cycles", 32'(r_total - rsnap), (!bad && !t.we) ? 32'(W + 1) : 32'd0);
        if (!bad && t.we) begin
            chk("write_addr", 32'(last_w_addr), 32'(wd));
            chk("write_data", last_w_data, t.wdata);
        end
    endtask

    // Serves both queues; the model predicts which port acks on which cycle.
    task automatic run_phase(input int p_start);
        txn_t cur [2];
        bit   act [2];
        int   win, wait_n, cyc, wsnap, rsnap;
        logic exp_pa, exp_la;
        win = -1; wait_n = 0; cyc = 0; wsnap = 0; rsnap = 0;
        act[0] = 1'b0; act[1] = 1'b0;
        cur[0] = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
        cur[1] = cur[0];
        forever begin
            if (!act[1] && lq.size() > 0) begin
                cur[1] = lq.pop_front(); act[1] = 1'b1; drive_port(1, 1'b1, cur[1]);
            end
            if (!act[0] && pq.size() > 0 && cyc >= p_start) begin
                cur[0] = pq.pop_front(); act[0] = 1'b1; drive_port(0, 1'b1, cur[0]);
            end
            if (win < 0 && (act[0] || act[1])) begin
                win    = pick_m(act[0], act[1], last_m);
                last_m = win;
                wait_n = txn_bad(cur[win]) ? 2 : W + 3;
                wsnap  = w_total;
                rsnap  = r_total;
            end
            if (win < 0 && pq.size() == 0 && lq.size() == 0) break;
            if (cyc >= 2000) begin
                checks++; errors++;
                $error("FAIL phase_budget: observed %0d cycles expected < 2000", cyc);
                break;
            end
            @(posedge clk); #1; cyc++;
            if (win >= 0) wait_n--;
            exp_pa = (win == 0) && (wait_n == 0);
            exp_la = (win == 1) && (wait_n == 0);
            chk("p_ack", 32'(p_ack), 32'(exp_pa));
            chk("l_ack", 32'(l_ack), 32'(exp_la));
            chk("p_stall", 32'(p_stall), 32'(act[0] && !exp_pa));
            if (win >= 0 && wait_n == 0) begin
                complete(win, cur[win], wsnap, rsnap);
                act[win] = 1'b0;
                drive_port(win, 1'b0, cur[win]);
                win = -1;
            end
        end
        @(posedge clk); #1;
        chk("idle_p_stall", 32'(p_stall), 32'd0);
        chk("idle_acks", 32'({p_ack, l_ack}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_acks"}, 32'({p_ack, l_ack}), 32'd0);
        chk({tag, "_errs"}, 32'({p_err, l_err}), 32'd0);
        chk({tag, "_mem_en"}, 32'({mem_r_en, mem_w_en}), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_st_val"}, mem_st_val, 32'd0);
        chk({tag, "_p_rdata"}, p_rdata, 32'd0);
        chk({tag, "_l_rdata"}, l_rdata, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wsave;
        txn_t idle_t;
        idle_t = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
        drive_port(0, 1'b0, idle_t);
        drive_port(1, 1'b0, idle_t);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        last_m = 1;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_p_stall", 32'(p_stall), 32'd0);
        seed_mem = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed: write/read 0x84, out-of-range 0x100, misaligned 0x6.
        pq.push_back('{we: 1'b1, addr: 32'h84, wdata: 32'hDEADBEEF});
        pq.push_back('{we: 1'b0, addr: 32'h84, wdata: 32'h0});
        pq.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'h1111_2222});
        pq.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        pq.push_back('{we: 1'b0, addr: 32'h6, wdata: 32'h0});
        pq.push_back('{we: 1'b1, addr: 32'h6, wdata: 32'h3333_4444});
        run_phase(0);
        chk("p_rdata_0x84", p_rdata, 32'hDEADBEEF);
        chk("mem_word33", tb_mem[33], 32'hDEADBEEF);

        // Loader granted first, pipeline raised while it is busy.
        lq.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hA5A5_0001});
        pq.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
        run_phase(2);

        // Both ports contending with back-to-back requests.
        for (int i = 0; i < 4; i++) begin
            pq.push_back(rand_txn());
            lq.push_back(rand_txn());
        end
        run_phase(0);

        // Random traffic with a random pipeline start offset.
        for (int i = 0; i < 20; i++) begin
            pq.push_back(rand_txn());
            lq.push_back(rand_txn());
        end
        run_phase($urandom_range(0, 6));

        // Reset in the middle of a write access to 0x10.
        wsave = w_total;
        drive_port(0, 1'b1, '{we: 1'b1, addr: 32'h10, wdata: 32'hCAFE_F00D});
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        drive_port(0, 1'b0, idle_t);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_reset_acks", 32'({p_ack, l_ack}), 32'd0);
        end
        chk("midreset_no_commit", 32'(w_total - wsave), 32'd0);
        chk("midreset_word4", tb_mem[4], ref_mem[4]);
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        last_m = 1;
        pq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
        lq.push_back('{we: 1'b0, addr: 32'h84, wdata: 32'h0});
        run_phase(0);

        for (int i = 0; i < DEPTH; i++) chk($sformatf("final_mem%0d", i), tb_mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage and port 1 is the loader/debug port.
- Sequences each access through a fixed number of wait states.
- Returns read data with a one-cycle ack pulse.
- Generates the MEM-stage stall for the hazard unit.
- Sits between the EX/MEM pipeline register, the loader, and the data memory.

Parameters:
- WAIT_CYCLES, 1: extra memory wait states per access (0..15).
- DEPTH, 64: data memory depth in 32-bit words.
- AW, 6: memory word-address width, equal to clog2(DEPTH).

Ports:
- clk  in  1  system clock; all flops update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_req  in  1  pipeline access request; held until p_ack.
- p_we  in  1  pipeline write (1) / read (0).
- p_addr  in  32  pipeline byte address.
- p_wdata  in  32  pipeline store value.
- p_ack  out  1  one-cycle completion pulse to the pipeline.
- p_rdata  out  32  pipeline load data, valid while p_ack is high.
- p_err  out  1  out-of-range flag, valid while p_ack is high.
- p_stall  out  1  stall to the hazard unit.
- l_req, l_we, l_addr, l_wdata, l_ack, l_rdata, l_err: loader-port equivalents of the p_* signals (same directions and widths).
- mem_r_en  out  1  data memory read enable.
- mem_w_en  out  1  data memory write enable.
- mem_addr  out  AW  memory word address.
- mem_st_val  out  32  memory write data.
- mem_rd_val  in  32  memory read data (combinational from the memory).

Behaviour:
- Reset is asynchronous on rst_n low. Reset state: FSM IDLE, all acks 0, all errs 0, mem_r_en 0, mem_w_en 0, mem_addr 0, mem_st_val 0, p_rdata and l_rdata 0, last_grant 1 (so port 0 wins first).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Request present: select the winner, latch its we/addr/wdata and owner ID.
  - Address word index addr[31:2] >= DEPTH, or addr[1:0] != 0: set err_q and go to DONE directly. No memory enable is asserted.
  - Otherwise load cnt = WAIT_CYCLES and go to ACCESS.
- ACCESS:
  - mem_addr = latched addr[AW+1:2]; mem_st_val = latched wdata throughout.
  - mem_r_en is high for all ACCESS cycles of a read.
  - mem_w_en is high only in the cycle where cnt == 0, so each access commits exactly one write.
  - cnt decrements each cycle.
  - At cnt == 0: capture mem_rd_val into the owner's rdata register (reads only) and go to DONE.
- DONE:
  - Owner's ack = 1 for exactly one cycle, with err = err_q. Non-owner ack stays 0.
  - Return to IDLE. A req still high is arbitrated as a new request in IDLE; there is no back-to-back bypass.
- Latency: req sampled in IDLE at edge k gives ack high in the cycle after edge k+WAIT_CYCLES+2. With the default WAIT_CYCLES=1 this is 3 edges.
- Error latency: 1 edge (ack in the cycle after edge k+1).
- rdata holds its value until the owner's next completed read. Writes and errors do not modify rdata.
- p_stall = p_req & ~p_ack (combinational). l_req does not affect p_stall except through arbitration delay.
- Requests arriving while busy wait. A requester must hold req/we/addr/wdata stable until its ack; changes during ACCESS are ignored because the values are latched.
- Simultaneous requests in IDLE: resolved by arbitration. last_grant updates on every grant.
- Reset mid-ACCESS: the access is aborted, no write commits, no ack is issued, and the requester must re-request.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the port not equal to last_grant wins.
- Undefined: fixed priority, port 0 (pipeline) always wins ties. last_grant is still maintained but unused.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE/ACCESS/DONE).
  - Port-ID constants PORT_PIPE=0 and PORT_LOAD=1.
  - Default WAIT_CYCLES and DEPTH constants.
- One natural sub-module: dmem_arb_pick. It is combinational: takes p_req, l_req, last_grant and outputs grant_valid and grant_id. It holds the DMEM_ARB_RR_EN switch.

Test Plan:
- Single pipeline write then read, WAIT_CYCLES=1:
  - p_req, we=1, addr=0x84, wdata=0xDEADBEEF → mem_w_en high for one cycle at mem_addr=33; p_ack 3 edges after request.
  - Subsequent read of 0x84 → p_rdata=0xDEADBEEF, p_err=0.
- Simultaneous p_req and l_req, repeated 4 times:
  - RR enabled: grants alternate 0,1,0,1.
  - RR disabled: port 0 always wins while p_req is reasserted; the loader completes only when p_req is idle.
- Out-of-range access, addr=0x100 (word 64):
  - p_ack with p_err=1 after 1 edge.
  - mem_w_en and mem_r_en never asserted; memory contents unchanged.
- Misaligned access, addr=0x6 → p_err=1, no memory enable asserted.
- Stall: l_req granted first, then p_req raised → p_stall high every cycle until p_ack; p_stall low in the cycle after the ack.
- Reset mid-operation: rst_n pulled low during ACCESS of a write to 0x10 → no write commits (word 4 unchanged), no ack, all outputs at reset values immediately.
